// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - player/score-side signal bundle for the game round sequencer
//
// Purpose: groups the start/user_input controls and the registered game outputs
//          so the sequencer and its environment share one port.
// Signals:
//   start        level request to begin a game (sampled each tick)
//   user_input   player switch pattern
//   pattern      target pattern, 8'h00 = blank
//   score_clear  one-tick pulse that clears the score calculator
//   round_num    0-based index of the current round
//   hit_count    rounds matched this game, saturating
//   hit / miss   one-tick round result pulses
//   busy         high while a game is running
//   game_over    high once all rounds have been played
// Modports: master drives start/user_input, slave (the sequencer) drives the rest.
interface game_sequencer_if;
  logic       start;
  logic [7:0] user_input;
  logic [7:0] pattern;
  logic       score_clear;
  logic [7:0] round_num;
  logic [7:0] hit_count;
  logic       hit;
  logic       miss;
  logic       busy;
  logic       game_over;

  modport master (
    output start, user_input,
    input  pattern, score_clear, round_num, hit_count, hit, miss, busy, game_over
  );

  modport slave (
    input  start, user_input,
    output pattern, score_clear, round_num, hit_count, hit, miss, busy, game_over
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round sequencer for the pattern-matching game
//
// Purpose: per round shows a pseudo-random non-blank 8-bit pattern until the
//          player matches it or HOLD_TICKS expire, blanks for GAP_TICKS, and
//          ends the game after ROUNDS rounds. All outputs are registered.
// Ports:
//   counter10h  in  game tick clock (10 Hz), all state changes on rising edge
//   reset       in  asynchronous active-high reset
//   bus         slave side of game_sequencer_if (start/user_input in, status out)
module game_sequencer #(
  parameter int         ROUNDS     = 16,
  parameter int         HOLD_TICKS = 40,
  parameter int         GAP_TICKS  = 5,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic              counter10h,
  input  logic              reset,
  game_sequencer_if.slave   bus
);

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);
  localparam logic [7:0] ROUND_LAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHOW,
    S_GAP,
    S_OVER
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lfsr, w_lfsr_nxt;
  logic [7:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [7:0] r_pattern, w_pattern_nxt;
  logic [7:0] r_round_num, w_round_num_nxt;
  logic [7:0] r_hit_count, w_hit_count_nxt;
  logic       r_score_clear, w_score_clear_nxt;
  logic       r_hit, w_hit_nxt;
  logic       r_miss, w_miss_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_game_over, w_game_over_nxt;
  logic [7:0] w_lfsr_step;

  // Maximal-length Fibonacci LFSR (taps 8,6,5,4); never reaches zero from a
  // nonzero seed and never repeats a value back-to-back.
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_comb begin
    w_state_nxt       = r_state;
    w_lfsr_nxt        = r_lfsr;
    w_tick_cnt_nxt    = r_tick_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_pattern_nxt     = r_pattern;
    w_round_num_nxt   = r_round_num;
    w_hit_count_nxt   = r_hit_count;
    w_score_clear_nxt = 1'b0;
    w_hit_nxt         = 1'b0;
    w_miss_nxt        = 1'b0;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          w_state_nxt       = S_CLEAR;
          w_score_clear_nxt = 1'b1;
          w_round_num_nxt   = 8'h00;
          w_hit_count_nxt   = 8'h00;
          w_pattern_nxt     = 8'h00;
        end
      end

      S_CLEAR: begin
        w_state_nxt    = S_SHOW;
        w_lfsr_nxt     = w_lfsr_step;
        w_pattern_nxt  = w_lfsr_step;
        w_tick_cnt_nxt = 8'h00;
      end

      S_SHOW: begin
        // Matching is suppressed on the first shown tick so the score
        // calculator latches the new pattern before a hit can be scored.
        if ((r_tick_cnt != 8'h00) && (bus.user_input == r_pattern)) begin
          w_hit_nxt       = 1'b1;
          w_hit_count_nxt = (r_hit_count == 8'hFF) ? 8'hFF : r_hit_count + 8'h01;
          w_state_nxt     = S_GAP;
          w_pattern_nxt   = 8'h00;
          w_gap_cnt_nxt   = 8'h00;
        end else if (r_tick_cnt == HOLD_LAST) begin
          w_miss_nxt    = 1'b1;
          w_state_nxt   = S_GAP;
          w_pattern_nxt = 8'h00;
          w_gap_cnt_nxt = 8'h00;
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + 8'h01;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          if (r_round_num == ROUND_LAST) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt     = S_SHOW;
            w_round_num_nxt = r_round_num + 8'h01;
            w_lfsr_nxt      = w_lfsr_step;
            w_pattern_nxt   = w_lfsr_step;
            w_tick_cnt_nxt  = 8'h00;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'h01;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Status flags follow the state being entered so they are valid with it.
    w_busy_nxt      = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_SHOW) ||
                      (w_state_nxt == S_GAP);
    w_game_over_nxt = (w_state_nxt == S_OVER);
  end

  always_ff @(posedge counter10h or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_tick_cnt    <= 8'h00;
      r_gap_cnt     <= 8'h00;
      r_pattern     <= 8'h00;
      r_round_num   <= 8'h00;
      r_hit_count   <= 8'h00;
      r_score_clear <= 1'b0;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      r_busy        <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lfsr        <= w_lfsr_nxt;
      r_tick_cnt    <= w_tick_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_pattern     <= w_pattern_nxt;
      r_round_num   <= w_round_num_nxt;
      r_hit_count   <= w_hit_count_nxt;
      r_score_clear <= w_score_clear_nxt;
      r_hit         <= w_hit_nxt;
      r_miss        <= w_miss_nxt;
      r_busy        <= w_busy_nxt;
      r_game_over   <= w_game_over_nxt;
    end
  end

  assign bus.pattern     = r_pattern;
  assign bus.score_clear = r_score_clear;
  assign bus.round_num   = r_round_num;
  assign bus.hit_count   = r_hit_count;
  assign bus.hit         = r_hit;
  assign bus.miss        = r_miss;
  assign bus.busy        = r_busy;
  assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  game_sequencer_if bus ();

  game_sequencer #(
    .ROUNDS    (2),
    .HOLD_TICKS(40),
    .GAP_TICKS (5),
    .SEED      (8'hA5)
  ) dut (
    .counter10h(clk),
    .reset     (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pat, input logic sc,
                         input logic [7:0] rnd, input logic [7:0] hc, input logic h,
                         input logic m, input logic b, input logic go);
    chk({tag, ".pattern"},     bus.pattern,            pat);
    chk({tag, ".score_clear"}, {7'd0, bus.score_clear}, {7'd0, sc});
    chk({tag, ".round_num"},   bus.round_num,          rnd);
    chk({tag, ".hit_count"},   bus.hit_count,          hc);
    chk({tag, ".hit"},         {7'd0, bus.hit},        {7'd0, h});
    chk({tag, ".miss"},        {7'd0, bus.miss},       {7'd0, m});
    chk({tag, ".busy"},        {7'd0, bus.busy},       {7'd0, b});
    chk({tag, ".game_over"},   {7'd0, bus.game_over},  {7'd0, go});
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.user_input = 8'h00;
    #2;
    chk_all("reset", 8'h00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Game 1, round 0: start, clear pulse, first pattern 4A, then timeout.
    bus.start = 1'b1;
    tick();
    chk_all("clear", 8'h00, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();
    chk_all("show_r0", 8'h4A, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 40; i++) begin
      tick();
      chk("r0_hold.miss", {7'd0, bus.miss}, 8'h00);
      chk("r0_hold.pattern", bus.pattern, 8'h4A);
    end
    tick();
    chk_all("r0_miss", 8'h00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r0_gap.pattern", bus.pattern, 8'h00);
      chk("r0_gap.miss", {7'd0, bus.miss}, 8'h00);
      chk("r0_gap.busy", {7'd0, bus.busy}, 8'h01);
    end

    // Round 1: player matches from the first shown tick; hit only at tick_cnt 1.
    bus.user_input = 8'h95;
    tick();
    chk_all("show_r1", 8'h95, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("nohit_t0", 8'h95, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("hit_t1", 8'h00, 1'b0, 8'd1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.user_input = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r1_gap.busy", {7'd0, bus.busy}, 8'h01);
    end
    tick();
    chk_all("over", 8'h00, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("over_hold", 8'h00, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Game 2: LFSR continues (2A), match lands exactly on the last hold tick.
    bus.start = 1'b1;
    tick();
    chk_all("clear2", 8'h00, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();
    chk_all("show_g2", 8'h2A, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 40; i++) begin
      tick();
      chk("g2_hold.miss", {7'd0, bus.miss}, 8'h00);
      chk("g2_hold.hit", {7'd0, bus.hit}, 8'h00);
    end
    bus.user_input = 8'h2A;
    tick();
    chk_all("hit_last", 8'h00, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.user_input = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    chk_all("show_g2r1", 8'h54, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();

    // Asynchronous reset in SHOW clears everything before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    chk_all("clear3", 8'h00, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();
    chk_all("show_g3", 8'h4A, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
